// File: rtl/dual_issue_router_if.sv
// ============================================================================
// Module      : dual_issue_router_if
// Description : Fetch-to-issue bundle between the fetch stage and the router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dual_issue_router_if;
    logic [0:31] first_inst;
    logic [0:31] second_inst;
    logic [0:31] pair_pc;
    logic        branch_taken;
    logic        ex_stall;
    logic        stall;
    logic [0:31] even_inst;
    logic [0:31] odd_inst;
    logic [0:31] even_pc;
    logic [0:31] odd_pc;

    modport master (
        output first_inst, second_inst, pair_pc, branch_taken, ex_stall,
        input  stall, even_inst, odd_inst, even_pc, odd_pc
    );

    modport slave (
        input  first_inst, second_inst, pair_pc, branch_taken, ex_stall,
        output stall, even_inst, odd_inst, even_pc, odd_pc
    );
endinterface

`default_nettype wire

// File: rtl/dual_issue_router.sv
// ============================================================================
// Module      : dual_issue_router
// Description : Routes a two-slot fetch packet to even/odd issue ports,
//               splitting non-dual-issuable packets over two cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_issue_router (
    input  logic               clock,
    input  logic               reset,
    dual_issue_router_if.slave bus
);

    localparam logic [0:31] c_NOP_EVEN = {11'b01000000001, 21'b0};
    localparam logic [0:31] c_NOP_ODD  = {11'b00000000001, 21'b0};

    typedef enum logic [0:0] {
        ST_PAIR  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [0:31] r_hold_inst;
    logic [0:31] r_hold_pc;
    logic        r_hold_odd;
    logic [0:31] r_even_inst;
    logic [0:31] r_odd_inst;
    logic [0:31] r_even_pc;
    logic [0:31] r_odd_pc;

    state_t      w_nxt_state;
    logic [0:31] w_nxt_hold_inst;
    logic [0:31] w_nxt_hold_pc;
    logic        w_nxt_hold_odd;
    logic [0:31] w_nxt_even_inst;
    logic [0:31] w_nxt_odd_inst;
    logic [0:31] w_nxt_even_pc;
    logic [0:31] w_nxt_odd_pc;
    logic        w_fsm_stall;

    logic        w_first_odd;
    logic        w_second_odd;
    logic        w_first_filler;
    logic        w_raw;
    logic        w_dual;
    logic [0:31] w_second_pc;

    assign w_first_odd  = (bus.first_inst[0:10] == 11'b00000000001) ||
                          (bus.first_inst[0:2] == 3'b001);
    assign w_second_odd = (bus.second_inst[0:10] == 11'b00000000001) ||
                          (bus.second_inst[0:2] == 3'b001);

    // RAW is checked on raw field positions for every format; a false split is harmless.
    assign w_first_filler = (bus.first_inst[0:10] == c_NOP_EVEN[0:10]) ||
                            (bus.first_inst[0:10] == c_NOP_ODD[0:10]);
    assign w_raw  = !w_first_filler &&
                    ((bus.second_inst[18:24] == bus.first_inst[25:31]) ||
                     (bus.second_inst[11:17] == bus.first_inst[25:31]));
    assign w_dual = (w_first_odd != w_second_odd) && !w_raw;
    assign w_second_pc = bus.pair_pc + 32'd4;

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_hold_inst = r_hold_inst;
        w_nxt_hold_pc   = r_hold_pc;
        w_nxt_hold_odd  = r_hold_odd;
        w_nxt_even_inst = r_even_inst;
        w_nxt_odd_inst  = r_odd_inst;
        w_nxt_even_pc   = r_even_pc;
        w_nxt_odd_pc    = r_odd_pc;
        w_fsm_stall     = 1'b0;

        if (bus.branch_taken) begin
            w_nxt_state     = ST_PAIR;
            w_nxt_hold_inst = '0;
            w_nxt_hold_pc   = '0;
            w_nxt_hold_odd  = 1'b0;
            w_nxt_even_inst = c_NOP_EVEN;
            w_nxt_odd_inst  = c_NOP_ODD;
            w_nxt_even_pc   = '0;
            w_nxt_odd_pc    = '0;
        end else if (bus.ex_stall) begin
            w_fsm_stall = 1'b1;
        end else begin
            case (r_state)
                ST_PAIR: begin
                    if (w_dual) begin
                        if (w_first_odd) begin
                            w_nxt_odd_inst  = bus.first_inst;
                            w_nxt_odd_pc    = bus.pair_pc;
                            w_nxt_even_inst = bus.second_inst;
                            w_nxt_even_pc   = w_second_pc;
                        end else begin
                            w_nxt_even_inst = bus.first_inst;
                            w_nxt_even_pc   = bus.pair_pc;
                            w_nxt_odd_inst  = bus.second_inst;
                            w_nxt_odd_pc    = w_second_pc;
                        end
                    end else begin
                        w_nxt_even_inst = w_first_odd ? c_NOP_EVEN : bus.first_inst;
                        w_nxt_odd_inst  = w_first_odd ? bus.first_inst : c_NOP_ODD;
                        w_nxt_even_pc   = bus.pair_pc;
                        w_nxt_odd_pc    = bus.pair_pc;
                        w_nxt_hold_inst = bus.second_inst;
                        w_nxt_hold_pc   = w_second_pc;
                        w_nxt_hold_odd  = w_second_odd;
                        w_nxt_state     = ST_SPLIT;
                        w_fsm_stall     = 1'b1;
                    end
                end
                default: begin
                    // Packet inputs are ignored here; fetch is re-presenting the same pair.
                    w_nxt_even_inst = r_hold_odd ? c_NOP_EVEN : r_hold_inst;
                    w_nxt_odd_inst  = r_hold_odd ? r_hold_inst : c_NOP_ODD;
                    w_nxt_even_pc   = r_hold_pc;
                    w_nxt_odd_pc    = r_hold_pc;
                    w_nxt_state     = ST_PAIR;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_PAIR;
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
            r_hold_odd  <= 1'b0;
            r_even_inst <= c_NOP_EVEN;
            r_odd_inst  <= c_NOP_ODD;
            r_even_pc   <= '0;
            r_odd_pc    <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_hold_inst <= w_nxt_hold_inst;
            r_hold_pc   <= w_nxt_hold_pc;
            r_hold_odd  <= w_nxt_hold_odd;
            r_even_inst <= w_nxt_even_inst;
            r_odd_inst  <= w_nxt_odd_inst;
            r_even_pc   <= w_nxt_even_pc;
            r_odd_pc    <= w_nxt_odd_pc;
        end
    end

    assign bus.stall     = !reset && w_fsm_stall;
    assign bus.even_inst = r_even_inst;
    assign bus.odd_inst  = r_odd_inst;
    assign bus.even_pc   = r_even_pc;
    assign bus.odd_pc    = r_odd_pc;

endmodule

`default_nettype wire

// File: tb/tb_dual_issue_router.sv
// ============================================================================
// Module      : tb_dual_issue_router
// Description : Directed plus random stimulus against an issue-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_issue_router;

    localparam logic [0:31] c_NOP_EVEN = {11'b01000000001, 21'b0};
    localparam logic [0:31] c_NOP_ODD  = {11'b00000000001, 21'b0};
    localparam logic [0:10] c_OP_ADD   = 11'b00011000000;
    localparam logic [0:10] c_OP_LQD   = 11'b00110100000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dual_issue_router_if bus ();

    dual_issue_router dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: issued bundle plus a queue of instructions still owed.
    logic [0:31] m_even, m_odd, m_even_pc, m_odd_pc;
    logic [0:31] q_inst[$];
    logic [0:31] q_pc[$];
    logic        last_stall;

    function automatic logic is_odd(input logic [0:31] x);
        return (x[0:10] == 11'b00000000001) || (x[0:2] == 3'b001);
    endfunction

    function automatic logic can_pair(input logic [0:31] f, input logic [0:31] s);
        logic filler, raw;
        filler = (f[0:10] == c_NOP_EVEN[0:10]) || (f[0:10] == c_NOP_ODD[0:10]);
        raw    = !filler && ((s[18:24] == f[25:31]) || (s[11:17] == f[25:31]));
        return (is_odd(f) != is_odd(s)) && !raw;
    endfunction

    function automatic logic [0:31] mk(input logic [0:10] op, input logic [6:0] rb,
                                       input logic [6:0] ra, input logic [6:0] rt);
        return {op, rb, ra, rt};
    endfunction

    function automatic logic [0:31] rnd_inst();
        logic [0:31] x;
        int k;
        x = $urandom;
        k = $urandom_range(0, 9);
        if (k < 5) x[0:2] = 3'b001;
        else       x[0]   = 1'b1;
        x[25:31] = 7'($urandom_range(0, 5));
        x[18:24] = 7'($urandom_range(0, 5));
        x[11:17] = 7'($urandom_range(0, 5));
        if (k == 8) x = c_NOP_EVEN;
        if (k == 9) x = c_NOP_ODD;
        return x;
    endfunction

    task automatic issue_one(input logic [0:31] inst, input logic [0:31] pc);
        m_even    = is_odd(inst) ? c_NOP_EVEN : inst;
        m_odd     = is_odd(inst) ? inst : c_NOP_ODD;
        m_even_pc = pc;
        m_odd_pc  = pc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic bt, input logic exs,
                        input logic [0:31] f, input logic [0:31] s, input logic [0:31] pc);
        logic exp_stall;
        @(negedge clk);
        rst              = r;
        bus.branch_taken = bt;
        bus.ex_stall     = exs;
        bus.first_inst   = f;
        bus.second_inst  = s;
        bus.pair_pc      = pc;
        #1;
        exp_stall = !r && !bt && (exs || (q_inst.size() == 0 && !can_pair(f, s)));
        chk("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
        last_stall = exp_stall;
        @(posedge clk);
        if (r || bt) begin
            m_even = c_NOP_EVEN; m_odd = c_NOP_ODD; m_even_pc = '0; m_odd_pc = '0;
            q_inst.delete(); q_pc.delete();
        end else if (exs) begin
            // frozen: nothing moves
        end else if (q_inst.size() != 0) begin
            issue_one(q_inst.pop_front(), q_pc.pop_front());
        end else if (can_pair(f, s)) begin
            m_even    = is_odd(f) ? s : f;
            m_odd     = is_odd(f) ? f : s;
            m_even_pc = is_odd(f) ? pc + 32'd4 : pc;
            m_odd_pc  = is_odd(f) ? pc : pc + 32'd4;
        end else begin
            issue_one(f, pc);
            q_inst.push_back(s);
            q_pc.push_back(pc + 32'd4);
        end
        #1;
        chk("even_inst", bus.even_inst, m_even);
        chk("odd_inst",  bus.odd_inst,  m_odd);
        chk("even_pc",   bus.even_pc,   m_even_pc);
        chk("odd_pc",    bus.odd_pc,    m_odd_pc);
    endtask

    initial begin
        logic [0:31] add_i, lqd_i, e1, e2, raw_e, raw_o7, raw_o8, f, s, pc;
        int r;
        bus.first_inst = '0; bus.second_inst = '0; bus.pair_pc = '0;
        bus.branch_taken = 1'b0; bus.ex_stall = 1'b0;
        m_even = 'x; m_odd = 'x; m_even_pc = 'x; m_odd_pc = 'x;
        last_stall = 1'b0;

        add_i  = mk(c_OP_ADD, 7'd2, 7'd1, 7'd3);
        lqd_i  = mk(c_OP_LQD, 7'd0, 7'd4, 7'd5);
        e1     = mk(c_OP_ADD, 7'd10, 7'd11, 7'd12);
        e2     = mk(c_OP_ADD, 7'd13, 7'd14, 7'd15);
        raw_e  = mk(c_OP_ADD, 7'd1, 7'd2, 7'd7);
        raw_o7 = mk(c_OP_LQD, 7'd0, 7'd7, 7'd9);
        raw_o8 = mk(c_OP_LQD, 7'd0, 7'd8, 7'd9);

        step(1, 0, 0, add_i, lqd_i, 32'h10);
        step(1, 0, 0, add_i, lqd_i, 32'h10);
        step(0, 0, 0, add_i, lqd_i, 32'h10);
        step(0, 0, 0, lqd_i, add_i, 32'h20);
        step(0, 0, 0, e1, e2, 32'h40);
        step(0, 0, 0, e1, e2, 32'h40);
        step(0, 0, 0, raw_e, raw_o7, 32'h80);
        step(0, 0, 0, raw_e, raw_o7, 32'h80);
        step(0, 0, 0, raw_e, raw_o8, 32'h90);
        step(0, 0, 0, e1, e2, 32'h50);
        step(0, 1, 0, e1, e2, 32'h50);
        step(0, 0, 0, add_i, lqd_i, 32'h58);
        step(0, 0, 0, e1, e2, 32'h60);
        step(0, 0, 1, e1, e2, 32'h60);
        step(0, 0, 1, e1, e2, 32'h60);
        step(0, 0, 1, e1, e2, 32'h60);
        step(0, 0, 0, e1, e2, 32'h60);
        step(0, 0, 0, e1, e2, 32'hFFFF_FFFC);
        step(0, 0, 0, e1, e2, 32'hFFFF_FFFC);
        step(0, 0, 0, e1, e2, 32'h70);
        step(1, 0, 0, e1, e2, 32'h70);
        step(0, 0, 0, lqd_i, add_i, 32'hFFFF_FFFC);

        f = rnd_inst(); s = rnd_inst(); pc = $urandom;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                f = rnd_inst(); s = rnd_inst(); pc = {$urandom} & 32'hFFFF_FFFC;
            end
            r = $urandom_range(0, 99);
            step(r < 2, (r >= 2) && (r < 8), (r >= 8) && (r < 20), f, s, pc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dual_issue_router.md
# dual_issue_router

Consumer end of the fetch interface: accepts the two-instruction packet from the fetch stage each cycle, classifies each slot as even-pipe or odd-pipe, and routes the packet to the even and odd issue ports. When a packet cannot dual-issue, it splits the packet over two cycles by holding the second instruction and asserting `stall` back to fetch. It sits between fetch and the register-fetch/execute stages, and also applies branch flushes and back-pressure from execute.

## Interface
- `NOP_EVEN`, {11'b01000000001,21'b0}: even-pipe filler (nop).
- `NOP_ODD`, {11'b00000000001,21'b0}: odd-pipe filler (lnop).

- `clock` in 1: single clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `first_inst` in [0:31]: packet slot 0, older instruction.
- `second_inst` in [0:31]: packet slot 1.
- `pair_pc` in [0:31]: byte address of `first_inst`; `second_inst` is at `pair_pc`+4.
- `branch_taken` in 1: flush request from the branch unit.
- `ex_stall` in 1: freeze request from execute/hazard logic.
- `stall` out 1: combinational hold request to fetch.
- `even_inst` out [0:31]: registered instruction for the even pipe.
- `odd_inst` out [0:31]: registered instruction for the odd pipe.
- `even_pc` out [0:31]: registered PC of `even_inst`.
- `odd_pc` out [0:31]: registered PC of `odd_inst`.

## Operation
- **Opcode:** bits [0:10].
- **Odd class:** the opcode equals 11'b00000000001, or bits [0:2] equal 3'b001. Every other instruction is even class.
- **Register fields:** RT is [25:31], RA is [18:24], RB is [11:17].
- **RAW conflict:** `first_inst` is not a filler (neither `NOP_EVEN` nor `NOP_ODD` opcode), and `second_inst` RA or RB equals `first_inst` RT. The check is applied to all formats; false splits are accepted.
- **Dual-issuable:** the two slots are of different class and there is no RAW conflict.
- **FSM states:** PAIR and SPLIT. A hold register stores {inst, pc, class}.
- **PAIR, dual-issuable:**
  - Each slot is routed to the port of its class; swapped order is allowed.
  - `stall`=0. Stay in PAIR.
- **PAIR, not dual-issuable:**
  - `first_inst` goes to its class port; the other port gets its filler.
  - Latch `second_inst`, `pair_pc`+4 and its class into the hold register.
  - `stall`=1. Go to SPLIT.
- **SPLIT:**
  - Issue the held instruction on its class port; the other port gets its filler.
  - `stall`=0. Go to PAIR.
  - Packet inputs are ignored in this state; fetch presents the same packet.
- **Filler PCs:** a port carrying a filler gets the PC of the instruction issued alongside it. `pair_pc`/`second_inst` PC arithmetic is 32-bit and wraps modulo 2^32.
- **Priority (highest first):**
  1. `reset`
  2. `branch_taken`
  3. `ex_stall`
  4. FSM
- **`branch_taken`=1:**
  - At the next edge both ports get fillers and both PCs become 0.
  - The hold register is cleared and the state goes to PAIR.
  - `stall`=0 in that cycle, so fetch can redirect.
- **`ex_stall`=1 (without `branch_taken`):**
  - All registers and the state hold.
  - `stall`=1.
- **`stall` equation:** `stall` = !`reset` & !`branch_taken` & (`ex_stall` | (state==PAIR & !dual-issuable)).

## Timing
- Reset values at the first edge with `reset`=1:
  - `even_inst`=`NOP_EVEN`, `odd_inst`=`NOP_ODD`.
  - `even_pc`=0, `odd_pc`=0.
  - State PAIR, hold register cleared.
- `stall`=0 while `reset`=1.
- **Latency:** a packet present in cycle N appears on the issue ports after edge N+1.
- **Split packet:** slot 0 issues at edge N+1, and slot 1 issues at edge N+2.
- **Stall handshake:** `stall` is valid in the same cycle as the packet. Fetch samples it at the same edge and must not advance when it is 1.
- **Throughput:** 2 instructions per cycle when every packet dual-issues; 1 per cycle when every packet splits.
- **Reset mid-SPLIT:** the held instruction is discarded and the outputs return to their reset values.
- **`branch_taken` in SPLIT:** the held instruction is discarded and is never issued.
- **`ex_stall` in SPLIT:** the held instruction is kept and issues in the first cycle after `ex_stall` deasserts.

## Test plan
- **Reset:** assert `reset` 2 cycles, then drive packet {add r3 = r1,r2 (even); lqd r5 (odd, [0:2]=001)} with `pair_pc`=0x10. Required: reset values seen first; after the next edge `even_inst`=add, `even_pc`=0x10, `odd_inst`=lqd, `odd_pc`=0x14, `stall`=0 throughout.
- **Swap:** drive packet {odd, even} with `pair_pc`=0x20. Required: routed in one cycle, `odd_pc`=0x20, `even_pc`=0x24.
- **Structural split:** drive two even instructions with `pair_pc`=0x40. Required: `stall`=1 for one cycle; issue 1 is `even_inst`=slot0 (pc 0x40) with `odd_inst`=lnop; issue 2 is `even_inst`=slot1 (pc 0x44) with `odd_inst`=lnop; then `stall`=0.
- **RAW split:** drive slot0 even with RT=7 and slot1 odd with RA=7. Required: two-cycle split despite the different classes; an identical packet with RA=8 dual-issues.
- **Flush:** assert `branch_taken` in the SPLIT cycle. Required: both ports carry fillers, PCs=0, `stall`=0, the held instruction never appears, and the state returns to PAIR.
- **Freeze:** assert `ex_stall` for 3 cycles mid-SPLIT. Required: outputs constant and `stall`=1 for those 3 cycles; the held instruction issues in the cycle after release.
